// File: rtl/ll_pop_scheduler_if.sv
// Consumer-side stream of the pop scheduler: {list, data} words under a valid/ready handshake.
// The scheduler drives through the master modport and the consumer attaches through the slave modport.
interface ll_pop_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LIST_WIDTH = 1
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LIST_WIDTH-1:0] out_list;

  modport master (
    output out_valid,
    output out_data,
    output out_list,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_list,
    output out_ready
  );

endinterface

// File: rtl/ll_pop_scheduler.sv
// Dequeue engine: round-robin pops across the non-empty lists, reads the popped head from the data
// memory, and queues {list, data} in a 2-entry FIFO toward the consumer.
module ll_pop_scheduler #(
  parameter int NUM_LISTS  = 2,
  parameter int NUM_ELEMS  = 4,
  parameter int PTR_WIDTH  = $clog2(NUM_ELEMS),
  parameter int DATA_WIDTH = 8,
  parameter int LIST_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LISTS-1:0]  empty,
  input  logic [PTR_WIDTH-1:0]  popped_head,
  output logic [NUM_LISTS-1:0]  pop,
  output logic                  mem_ren,
  output logic [PTR_WIDTH-1:0]  mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  ll_pop_scheduler_if.master    out_if
);

  localparam int                    STEP_W    = LIST_WIDTH + 1;
  localparam logic [STEP_W-1:0]     N_LISTS_W = STEP_W'(NUM_LISTS);
  localparam logic [LIST_WIDTH-1:0] LAST_LIST = LIST_WIDTH'(NUM_LISTS - 1);

  // Arbitration and issue state
  logic [LIST_WIDTH-1:0] r_rr_ptr;
  logic                  r_inflight;
  logic [LIST_WIDTH-1:0] r_inflight_list;

  // Output FIFO state
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [LIST_WIDTH-1:0] r_fifo_list [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  logic                  w_grant_valid;
  logic [LIST_WIDTH-1:0] w_grant;
  logic [STEP_W-1:0]     w_cand;
  logic [LIST_WIDTH-1:0] w_rr_next;
  logic                  w_deq;
  logic                  w_credit;
  logic                  w_issue;

  // NOTE: every variable written in always_comb is given a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_cand        = '0;
    for (int k = 0; k < NUM_LISTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + STEP_W'(k);
      if (w_cand >= N_LISTS_W) w_cand = w_cand - N_LISTS_W;
      for (int i = 0; i < NUM_LISTS; i++) begin
        if (!w_grant_valid && (w_cand == STEP_W'(i)) && !empty[i]) begin
          w_grant_valid = 1'b1;
          w_grant       = LIST_WIDTH'(i);
        end
      end
    end
  end

  assign w_rr_next = (w_grant == LAST_LIST) ? '0 : w_grant + LIST_WIDTH'(1);

  // A same-cycle dequeue frees a slot, so it counts as credit for this cycle's pop.
  assign w_deq    = (r_occ != 2'd0) & out_if.out_ready;
  assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_deq});

  // rst_n gates the issue so pop drops the instant reset asserts, without waiting for a clock.
  assign w_issue = rst_n & w_grant_valid & w_credit;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      pop[i] = w_issue && (w_grant == LIST_WIDTH'(i));
    end
  end

  assign mem_ren   = w_issue;
  assign mem_raddr = popped_head;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the
  // values from before the edge regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_list <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_list <= w_grant;
        r_rr_ptr        <= w_rr_next;
      end
    end
  end

  // NOTE: the two FIFO entries are reset along with the pointers so that out_data and out_list
  // read zero after reset; this storage is tiny, unlike a RAM, which would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_list[0] <= '0;
      r_fifo_list[1] <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_occ          <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= mem_rdata;
        r_fifo_list[r_wr_ptr] <= r_inflight_list;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_deq};
    end
  end

  assign out_if.out_valid = (r_occ != 2'd0);
  assign out_if.out_data  = r_fifo_data[r_rd_ptr];
  assign out_if.out_list  = r_fifo_list[r_rd_ptr];

endmodule
